// File: rtl/fp16_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pkg
// Shared FP16 constants for the ALU's arithmetic blocks (divider today, the
// multiplier later). Holds field positions, exponent limits, the default
// saturation code and the divider's FSM state encoding.
// No ports; import with `import fp16_pkg::*;`.
// -----------------------------------------------------------------------------
package fp16_pkg;

    // Field positions inside a 16-bit half-precision word.
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int FRAC_MSB = 9;

    // Unbiased exponent limits, 7-bit signed so that quotient exponents in
    // [-41,40] are representable without wrap.
    localparam logic signed [6:0] BIAS        = 7'sd15;
    localparam logic signed [6:0] EMIN        = -7'sd14;
    localparam logic signed [6:0] EMAX        = 7'sd15;
    localparam logic signed [6:0] EDENORM_MIN = -7'sd24;

    // Code produced on overflow and on any division by zero.
    localparam logic [15:0] SAT_CODE_DEFAULT = 16'hFFFF;

    // One quotient bit per DIV cycle; 12 bits give an 11-bit significand
    // plus one bit of normalisation headroom.
    localparam logic [3:0] DIV_LAST = 4'd11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NORM = 3'd1,
        DIV  = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/fp16_div_iter_lod10.sv
// -----------------------------------------------------------------------------
// lod10
// Leading-one detector for a 10-bit FP16 fraction. Reports the bit index of
// the most significant set bit; an all-zero input reports 0 (callers treat a
// zero operand separately).
// Ports:
//   value  in  10  fraction to scan
//   pos    out  4  index 0..9 of the highest set bit
// -----------------------------------------------------------------------------
module lod10 (
    input  logic [9:0] value,
    output logic [3:0] pos
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        pos = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (value[i]) pos = 4'(i);
        end
    end

endmodule

// File: rtl/fp16_div_iter.sv
// -----------------------------------------------------------------------------
// fp16_div_iter
// Iterative FP16 divider, A/B. Restoring radix-2 mantissa division, one
// quotient bit per cycle. Denormal inputs are normalised, E=31 is an ordinary
// exponent, results truncate, overflow and x/0 give SAT_CODE, results below
// 2^-24 flush to 16'h0000.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready_o is high only in IDLE; out_valid_o is high only in
// DONE, where DIV_o is held until out_ready_i is seen. One operation in
// flight; accept edge to out_valid_o rising is always 14 edges.
//
// Ports:
//   clk_i        in   1  clock
//   rst_i        in   1  asynchronous active-high reset
//   in_valid_i   in   1  operand pair valid
//   in_ready_o   out  1  operands can be accepted
//   opA_i        in  16  dividend
//   opB_i        in  16  divisor
//   out_valid_o  out  1  DIV_o valid
//   out_ready_i  in   1  consumer accepts DIV_o
//   DIV_o        out 16  quotient
//   state_dbg    out  3  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module fp16_div_iter
    import fp16_pkg::*;
#(
    parameter logic [15:0] SAT_CODE = SAT_CODE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] DIV_o,
    output logic [2:0]  state_dbg
);

    state_t state, state_nxt;

    // Operand capture and working registers.
    logic [15:0]       a_q, b_q;
    logic              sign_q, za_q, zb_q;
    logic [10:0]       mb_q;
    logic [11:0]       rem_q;
    logic [11:0]       quo_q;
    logic [3:0]        cnt_q;
    logic signed [6:0] exp_q;
    logic [15:0]       div_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid_i) state_nxt = NORM;
            NORM:    state_nxt = DIV;
            DIV:     if (cnt_q == DIV_LAST) state_nxt = PACK;
            PACK:    state_nxt = DONE;
            DONE:    if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign DIV_o       = div_q;
    assign state_dbg   = state;

    // --------------------------------------------------------- NORM logic
    logic [3:0]        pos_a, pos_b;
    logic [4:0]        exp_a, exp_b;
    logic              norm_a, norm_b;
    logic [10:0]       ma_n, mb_n;
    logic signed [6:0] ea_n, eb_n;

    lod10 u_lod_a (.value(a_q[FRAC_MSB:0]), .pos(pos_a));
    lod10 u_lod_b (.value(b_q[FRAC_MSB:0]), .pos(pos_b));

    // A denormal fraction with its top one at bit p is shifted left by 10-p
    // to reach bit 10, so its exponent is -14-(10-p) = p-24.
    always_comb begin
        exp_a  = a_q[EXP_MSB:EXP_LSB];
        exp_b  = b_q[EXP_MSB:EXP_LSB];
        norm_a = (exp_a != 5'd0);
        norm_b = (exp_b != 5'd0);
        ma_n   = norm_a ? {1'b1, a_q[FRAC_MSB:0]}
                        : ({1'b0, a_q[FRAC_MSB:0]} << (4'd10 - pos_a));
        mb_n   = norm_b ? {1'b1, b_q[FRAC_MSB:0]}
                        : ({1'b0, b_q[FRAC_MSB:0]} << (4'd10 - pos_b));
        ea_n   = norm_a ? ($signed({2'b00, exp_a}) - BIAS)
                        : (EDENORM_MIN + $signed({3'b000, pos_a}));
        eb_n   = norm_b ? ($signed({2'b00, exp_b}) - BIAS)
                        : (EDENORM_MIN + $signed({3'b000, pos_b}));
    end

    // ---------------------------------------------------------- DIV step
    logic        ge;
    logic [11:0] rem_sel;

    always_comb begin
        ge      = (rem_q >= {1'b0, mb_q});
        rem_sel = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    end

    // --------------------------------------------------------- PACK logic
    logic [10:0]       m_n;
    logic signed [6:0] e_n;
    logic [3:0]        sh_n;
    logic [9:0]        den_frac;
    logic [15:0]       pack_n;

    // Q[11] set means the quotient significand was >= 1: drop the extra LSB
    // and keep the exponent; otherwise the top bit is Q[10] and the exponent
    // is one lower.
    always_comb begin
        m_n      = quo_q[11] ? quo_q[11:1] : quo_q[10:0];
        e_n      = quo_q[11] ? exp_q : (exp_q - 7'sd1);
        sh_n     = 4'(EMIN - e_n);
        den_frac = 10'(m_n >> sh_n);
        if (zb_q)                   pack_n = SAT_CODE;
        else if (za_q)              pack_n = {sign_q, 15'b0};
        else if (e_n > EMAX)        pack_n = SAT_CODE;
        else if (e_n < EDENORM_MIN) pack_n = 16'h0000;
        else if (e_n >= EMIN)       pack_n = {sign_q, 5'(e_n + BIAS), m_n[FRAC_MSB:0]};
        else                        pack_n = {sign_q, 5'b00000, den_frac};
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= 16'h0000;
            b_q    <= 16'h0000;
            sign_q <= 1'b0;
            za_q   <= 1'b0;
            zb_q   <= 1'b0;
            mb_q   <= 11'd0;
            rem_q  <= 12'd0;
            quo_q  <= 12'd0;
            cnt_q  <= 4'd0;
            exp_q  <= 7'sd0;
            div_q  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q <= opA_i;
                        b_q <= opB_i;
                    end
                end
                NORM: begin
                    sign_q <= a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
                    za_q   <= (a_q[EXP_MSB:0] == 15'd0);
                    zb_q   <= (b_q[EXP_MSB:0] == 15'd0);
                    rem_q  <= {1'b0, ma_n};
                    mb_q   <= mb_n;
                    exp_q  <= ea_n - eb_n;
                    quo_q  <= 12'd0;
                    cnt_q  <= 4'd0;
                end
                DIV: begin
                    quo_q <= {quo_q[10:0], ge};
                    rem_q <= rem_sel << 1;
                    cnt_q <= cnt_q + 4'd1;
                end
                PACK: begin
                    div_q <= pack_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_div_iter.sv
// -----------------------------------------------------------------------------
// tb_fp16_div_iter
// Bench for fp16_div_iter: directed vectors, back-pressure, asynchronous
// reset mid-division, then random operand pairs against a reference model
// that computes the exact quotient in units of 2^-24 and truncates it onto
// the FP16 grid.
// -----------------------------------------------------------------------------
module tb_fp16_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] div;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    // ------------------------------------------------ clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    fp16_div_iter #(.SAT_CODE(16'hFFFF)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .opA_i       (op_a),
        .opB_i       (op_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .DIV_o       (div),
        .state_dbg   (state_dbg)
    );

    // --------------------------------------------------------- checking
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // ------------------------------------------------- reference model
    // Exact quotient in units of 2^-24, truncated; then mapped to the
    // largest FP16 code not above it.
    function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic [127:0] num, den, r, lim;
        logic [10:0]  ma, mb;
        int           ea, eb, sh, e;
        logic         s;
        logic [127:0] mant;
        s = a[15] ^ b[15];
        if (b[14:0] == 15'd0) return 16'hFFFF;
        if (a[14:0] == 15'd0) return {s, 15'b0};
        ma  = (a[14:10] == 5'd0) ? {1'b0, a[9:0]} : {1'b1, a[9:0]};
        mb  = (b[14:10] == 5'd0) ? {1'b0, b[9:0]} : {1'b1, b[9:0]};
        ea  = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        eb  = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
        // value = ma/mb * 2^(ea-eb); in 2^-24 units that is ma*2^(ea-eb+24)/mb
        sh  = ea - eb + 30;
        num = 128'(ma) << sh;
        den = 128'(mb) << 6;
        r   = num / den;
        lim = 128'd1 << 40;
        if (r >= lim) return 16'hFFFF;
        if (r == 128'd0) return 16'h0000;
        if (r < 128'd1024) return {s, 5'd0, r[9:0]};
        e = 1;
        while (r >= (128'd2048 << (e - 1))) e++;
        mant = r >> (e - 1);
        return {s, 5'(e), mant[9:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom_range(0, 65535));
        case ($urandom_range(0, 5))
            0: v[14:10] = 5'd0;
            1: v[14:10] = 5'd31;
            2: v[14:10] = 5'($urandom_range(10, 20));
            3: if ($urandom_range(0, 2) == 0) v[14:0] = 15'd0;
            default: ;
        endcase
        return v;
    endfunction

    // ----------------------------------------------------------- driver
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] expv, input string tag);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " ready"}, 32'(in_ready), 32'd1);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;          // accepting edge
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'd14);
        if (out_valid) check_eq({tag, " result"}, 32'(div), 32'(exp_q.pop_front()));
        else void'(exp_q.pop_front());
        @(posedge clk); #1;          // handshake edge (out_ready high)
        check_eq({tag, " back_idle"}, 32'(in_ready), 32'd1);
    endtask

    // --------------------------------------------------- directed table
    localparam int N_DIR = 13;
    logic [15:0] dir_a [N_DIR] = '{16'h3C00, 16'h4600, 16'h3C00, 16'h0001, 16'h0400,
                                   16'h0001, 16'h03FF, 16'h7BFF, 16'h3C00, 16'h0000,
                                   16'h0000, 16'h8000, 16'h7C00};
    logic [15:0] dir_b [N_DIR] = '{16'h3C00, 16'hC000, 16'h4200, 16'h0001, 16'h4000,
                                   16'h4000, 16'h3C00, 16'h1400, 16'h0000, 16'h0000,
                                   16'h3C00, 16'h3C00, 16'h7C00};
    logic [15:0] dir_q [N_DIR] = '{16'h3C00, 16'hC200, 16'h3555, 16'h3C00, 16'h0200,
                                   16'h0000, 16'h03FF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                   16'h0000, 16'h8000, 16'h3C00};

    // ------------------------------------------------------------ main
    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = 16'h0000;
        op_b      = 16'h0000;
        #1;
        check_eq("reset in_ready", 32'(in_ready), 32'd1);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset div", 32'(div), 32'h0000);
        check_eq("reset state", 32'(state_dbg), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < N_DIR; i++)
            run_op(dir_a[i], dir_b[i], dir_q[i], $sformatf("dir %h/%h", dir_a[i], dir_b[i]));

        // Back-pressure: result held, new operands ignored while busy.
        out_ready = 1'b0;
        op_a = 16'h3C00;
        op_b = 16'h4200;
        in_valid = 1'b1;
        exp_q.push_back(16'h3555);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("bp latency", 32'(n), 32'd14);
        check_eq("bp result", 32'(div), 32'(exp_q.pop_front()));
        op_a = 16'h4000;
        op_b = 16'h4000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("bp hold div", 32'(div), 32'h3555);
            check_eq("bp hold valid", 32'(out_valid), 32'd1);
            check_eq("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp release valid", 32'(out_valid), 32'd0);
        check_eq("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check_eq("bp nothing captured", 32'(state_dbg), 32'd0);

        // Asynchronous reset in the middle of the DIV phase.
        op_a = 16'h3C00;
        op_b = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst div", 32'(div), 32'h0000);
        check_eq("rst in_ready", 32'(in_ready), 32'd1);
        check_eq("rst state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("rst discarded op", 32'(seen), 32'd0);
        run_op(16'h4000, 16'h3C00, 16'h4000, "post_rst");

        // Random pairs against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, rb;
            ra = rand_op();
            rb = rand_op();
            run_op(ra, rb, ref_div(ra, rb), $sformatf("rand %h/%h", ra, rb));
        end

        check_eq("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
